// File: rtl/backprop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : backprop_sequencer
// Brief    : Captures one pass of forward z vectors, then issues per-layer
//            layer/sample/z/z_prev channels to the backpropagator, top down.
// Revision : 1.0  initial release
// ============================================================================
module backprop_sequencer #(
    parameter int NEURON_NUM          = 4,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int LAYER_ADDR_WIDTH    = 2,
    parameter int LAYER_MAX           = 3,
    parameter int SAMPLE_ADDR_SIZE    = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [SAMPLE_ADDR_SIZE-1:0]               sample_in,
    input  logic                                      sample_in_valid,
    output logic                                      sample_in_ready,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] fwd_z,
    input  logic                                      fwd_z_valid,
    output logic                                      fwd_z_ready,
    output logic [LAYER_ADDR_WIDTH-1:0]               layer,
    output logic                                      layer_valid,
    input  logic                                      layer_ready,
    output logic [SAMPLE_ADDR_SIZE-1:0]               sample,
    output logic                                      sample_valid,
    input  logic                                      sample_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z,
    output logic                                      z_valid,
    input  logic                                      z_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z_prev,
    output logic                                      z_prev_valid,
    input  logic                                      z_prev_ready,
    input  logic                                      update_done,
    output logic                                      busy,
    output logic                                      done
);

    localparam int ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_layer_max  = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_layer_top1 = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_layer_one  = LAYER_ADDR_WIDTH'(1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] c_layer_two  = LAYER_ADDR_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ISSUE   = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [LAYER_ADDR_WIDTH-1:0]   r_cnt;
    logic [LAYER_ADDR_WIDTH-1:0]   r_layer;
    logic [SAMPLE_ADDR_SIZE-1:0]   r_sample;
    logic [ZW-1:0]                 r_z;
    logic [ZW-1:0]                 r_z_prev;
    logic                          r_layer_valid;
    logic                          r_sample_valid;
    logic                          r_z_valid;
    logic                          r_z_prev_valid;
    logic                          r_done;
    logic [ZW-1:0]                 r_z_mem [0:LAYER_MAX];

    logic                          w_sample_hs;
    logic                          w_fwd_hs;
    logic                          w_capture_last;
    logic                          w_issue_done;
    logic                          w_update;
    logic                          w_next_round;
    logic                          w_finish;
    logic [LAYER_ADDR_WIDTH-1:0]   w_layer_dec;
    logic [LAYER_ADDR_WIDTH-1:0]   w_layer_dec2;

    assign w_sample_hs    = sample_in_valid && (r_state == S_IDLE);
    assign w_fwd_hs       = fwd_z_valid && (r_state == S_CAPTURE);
    assign w_capture_last = w_fwd_hs && (r_cnt == c_layer_max);
    // A channel is still owed while its valid is high and its ready is low.
    assign w_issue_done   = (r_state == S_ISSUE)
                          && !(r_layer_valid  && !layer_ready)
                          && !(r_sample_valid && !sample_ready)
                          && !(r_z_valid      && !z_ready)
                          && !(r_z_prev_valid && !z_prev_ready);
    assign w_update       = update_done && (r_state == S_WAIT);
    assign w_next_round   = w_update && (r_layer > c_layer_one);
    assign w_finish       = w_update && (r_layer == c_layer_one);
    assign w_layer_dec    = r_layer - c_layer_one;
    assign w_layer_dec2   = r_layer - c_layer_two;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_sample_hs)    w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_capture_last) w_state_next = S_ISSUE;
            S_ISSUE:   if (w_issue_done)   w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_next_round) begin
                    w_state_next = S_ISSUE;
                end else if (w_finish) begin
                    w_state_next = S_IDLE;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_layer        <= c_layer_max;
            r_sample       <= '0;
            r_z            <= '0;
            r_z_prev       <= '0;
            r_layer_valid  <= 1'b0;
            r_sample_valid <= 1'b0;
            r_z_valid      <= 1'b0;
            r_z_prev_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_sample_hs) begin
                r_sample <= sample_in;
                r_cnt    <= '0;
            end
            if (w_fwd_hs) begin
                r_cnt <= r_cnt + c_layer_one;
            end
            // The top vector is still being written this edge, so take it from the port.
            if (w_capture_last) begin
                r_layer        <= c_layer_max;
                r_z            <= fwd_z;
                r_z_prev       <= r_z_mem[c_layer_top1];
                r_layer_valid  <= 1'b1;
                r_sample_valid <= 1'b1;
                r_z_valid      <= 1'b1;
                r_z_prev_valid <= 1'b1;
            end else if (w_next_round) begin
                r_layer        <= w_layer_dec;
                r_z            <= r_z_mem[w_layer_dec];
                r_z_prev       <= r_z_mem[w_layer_dec2];
                r_layer_valid  <= 1'b1;
                r_sample_valid <= 1'b1;
                r_z_valid      <= 1'b1;
                r_z_prev_valid <= 1'b1;
            end else begin
                r_layer_valid  <= r_layer_valid  && !layer_ready;
                r_sample_valid <= r_sample_valid && !sample_ready;
                r_z_valid      <= r_z_valid      && !z_ready;
                r_z_prev_valid <= r_z_prev_valid && !z_prev_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fwd_hs) begin
            r_z_mem[r_cnt] <= fwd_z;
        end
    end

    assign sample_in_ready = (r_state == S_IDLE);
    assign fwd_z_ready     = (r_state == S_CAPTURE);
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign layer           = r_layer;
    assign layer_valid     = r_layer_valid;
    assign sample          = r_sample;
    assign sample_valid    = r_sample_valid;
    assign z               = r_z;
    assign z_valid         = r_z_valid;
    assign z_prev          = r_z_prev;
    assign z_prev_valid    = r_z_prev_valid;

endmodule
`default_nettype wire

// File: tb/tb_backprop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_backprop_sequencer
// Brief    : Scoreboard bench for backprop_sequencer; expected rounds queued at
//            capture time and compared at each channel handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_backprop_sequencer;

    localparam int NN = 4;
    localparam int NW = 10;
    localparam int LW = 2;
    localparam int LM = 3;
    localparam int SW = 10;
    localparam int ZW = NN * NW;

    logic          clk;
    logic          rst;
    logic [SW-1:0] sample_in;
    logic          sample_in_valid;
    logic          sample_in_ready;
    logic [ZW-1:0] fwd_z;
    logic          fwd_z_valid;
    logic          fwd_z_ready;
    logic [LW-1:0] layer;
    logic          layer_valid;
    logic          layer_ready;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic [ZW-1:0] z;
    logic          z_valid;
    logic          z_ready;
    logic [ZW-1:0] z_prev;
    logic          z_prev_valid;
    logic          z_prev_ready;
    logic          update_done;
    logic          busy;
    logic          done;

    typedef struct {
        logic [LW-1:0] layer;
        logic [ZW-1:0] z;
        logic [ZW-1:0] z_prev;
        logic [SW-1:0] sample;
    } exp_t;

    exp_t          exp_q[$];
    logic [ZW-1:0] zt [0:LM];
    int            n_pass;
    int            n_total;

    backprop_sequencer #(
        .NEURON_NUM          (NN),
        .NEURON_OUTPUT_WIDTH (NW),
        .LAYER_ADDR_WIDTH    (LW),
        .LAYER_MAX           (LM),
        .SAMPLE_ADDR_SIZE    (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .sample_in_ready (sample_in_ready),
        .fwd_z           (fwd_z),
        .fwd_z_valid     (fwd_z_valid),
        .fwd_z_ready     (fwd_z_ready),
        .layer           (layer),
        .layer_valid     (layer_valid),
        .layer_ready     (layer_ready),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .z               (z),
        .z_valid         (z_valid),
        .z_ready         (z_ready),
        .z_prev          (z_prev),
        .z_prev_valid    (z_prev_valid),
        .z_prev_ready    (z_prev_ready),
        .update_done     (update_done),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        sample_in_valid = 1'b0;
        fwd_z_valid     = 1'b0;
        layer_ready     = 1'b0;
        sample_ready    = 1'b0;
        z_ready         = 1'b0;
        z_prev_ready    = 1'b0;
        update_done     = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        n_total++; if (busy !== 1'b0) $display("FAIL %s busy: got %0b want 0", tag, busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL %s done: got %0b want 0", tag, done); else n_pass++;
        n_total++;
        if ({layer_valid, sample_valid, z_valid, z_prev_valid} !== 4'b0000)
            $display("FAIL %s valids: got %b want 0000", tag, {layer_valid, sample_valid, z_valid, z_prev_valid});
        else n_pass++;
        n_total++; if (layer !== 2'd3) $display("FAIL %s layer: got %0d want 3", tag, layer); else n_pass++;
        n_total++; if (sample !== '0) $display("FAIL %s sample: got %0d want 0", tag, sample); else n_pass++;
        n_total++;
        if (z !== '0 || z_prev !== '0) $display("FAIL %s z/z_prev: got %h/%h want 0/0", tag, z, z_prev);
        else n_pass++;
        n_total++;
        if ({sample_in_ready, fwd_z_ready} !== 2'b10)
            $display("FAIL %s readies: got %b want 10", tag, {sample_in_ready, fwd_z_ready});
        else n_pass++;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        test_reset(tag);
    endtask

    // Presents a sample then n_z forward vectors back to back.
    task automatic start_pass(input logic [SW-1:0] s, input int n_z, input bit ud_in_capture);
        exp_t e;
        sample_in       = s;
        sample_in_valid = 1'b1;
        cyc();
        sample_in_valid = 1'b0;
        n_total++;
        if ({busy, fwd_z_ready, sample_in_ready} !== 3'b110)
            $display("FAIL capture_entry: got %b want 110", {busy, fwd_z_ready, sample_in_ready});
        else n_pass++;
        for (int k = 0; k < n_z; k++) begin
            fwd_z       = zt[k];
            fwd_z_valid = 1'b1;
            update_done = ud_in_capture;
            cyc();
        end
        fwd_z_valid = 1'b0;
        update_done = 1'b0;
        if (n_z == LM + 1) begin
            for (int l = LM; l >= 1; l--) begin
                e.layer  = LW'(l);
                e.z      = zt[l];
                e.z_prev = zt[l-1];
                e.sample = s;
                exp_q.push_back(e);
            end
            n_total++;
            if ({layer_valid, sample_valid, z_valid, z_prev_valid, layer} !== {4'b1111, 2'd3})
                $display("FAIL issue_entry: got valids %b layer %0d want 1111 layer 3",
                         {layer_valid, sample_valid, z_valid, z_prev_valid}, layer);
            else n_pass++;
        end
    endtask

    // Serves one layer round: handshakes with per-channel ready delays, then WAIT and update_done.
    task automatic test_round(input string tag, input int lat_layer, input int lat_zprev,
                              input bit ud_in_issue, input bit intrude, input bit last);
        exp_t          e;
        bit            g_l, g_s, g_z, g_p;
        int            t;
        logic [LW-1:0] want_next;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s scoreboard: got empty queue want entry", tag);
            return;
        end
        e = exp_q.pop_front();
        g_l = 0; g_s = 0; g_z = 0; g_p = 0;
        t = 0;
        while (!(g_l && g_s && g_z && g_p) && t < 40) begin
            n_total++;
            if ({layer_valid, sample_valid, z_valid, z_prev_valid} !== {!g_l, !g_s, !g_z, !g_p})
                $display("FAIL %s hold t=%0d: got valids %b want %b", tag, t,
                         {layer_valid, sample_valid, z_valid, z_prev_valid}, {!g_l, !g_s, !g_z, !g_p});
            else n_pass++;
            layer_ready  = (t >= lat_layer);
            sample_ready = 1'b1;
            z_ready      = 1'b1;
            z_prev_ready = (t >= lat_zprev);
            update_done  = ud_in_issue && (t == 0);
            if (intrude && t == 0) begin
                sample_in       = 10'd77;
                sample_in_valid = 1'b1;
                fwd_z           = '1;
                fwd_z_valid     = 1'b1;
                n_total++;
                if ({busy, sample_in_ready, fwd_z_ready} !== 3'b100)
                    $display("FAIL %s busy_readies: got %b want 100", tag, {busy, sample_in_ready, fwd_z_ready});
                else n_pass++;
            end
            if (layer_valid && layer_ready && !g_l) begin
                g_l = 1; n_total++;
                if (layer !== e.layer) $display("FAIL %s layer: got %0d want %0d", tag, layer, e.layer);
                else n_pass++;
            end
            if (sample_valid && sample_ready && !g_s) begin
                g_s = 1; n_total++;
                if (sample !== e.sample) $display("FAIL %s sample: got %0d want %0d", tag, sample, e.sample);
                else n_pass++;
            end
            if (z_valid && z_ready && !g_z) begin
                g_z = 1; n_total++;
                if (z !== e.z) $display("FAIL %s z: got %h want %h", tag, z, e.z);
                else n_pass++;
            end
            if (z_prev_valid && !g_p) begin
                if (z_prev_ready) g_p = 1;
                n_total++;
                if (z_prev !== e.z_prev) $display("FAIL %s z_prev t=%0d: got %h want %h", tag, t, z_prev, e.z_prev);
                else n_pass++;
            end
            cyc();
            t++;
        end
        if (t >= 40) begin
            n_total++;
            $display("FAIL %s timeout: got %0d cycles want < 40", tag, t);
        end
        clear_inputs();
        n_total++;
        if ({busy, layer_valid, sample_valid, z_valid, z_prev_valid} !== 5'b10000)
            $display("FAIL %s wait_entry: got %b want 10000", tag,
                     {busy, layer_valid, sample_valid, z_valid, z_prev_valid});
        else n_pass++;
        cyc();
        cyc();
        n_total++;
        if (layer !== e.layer) $display("FAIL %s wait_layer: got %0d want %0d", tag, layer, e.layer);
        else n_pass++;
        update_done = 1'b1;
        cyc();
        update_done = 1'b0;
        if (last) begin
            n_total++;
            if ({done, busy, layer_valid, z_valid} !== 4'b1000)
                $display("FAIL %s done_pulse: got %b want 1000", tag, {done, busy, layer_valid, z_valid});
            else n_pass++;
            cyc();
            n_total++;
            if (done !== 1'b0) $display("FAIL %s done_width: got %0b want 0", tag, done);
            else n_pass++;
        end else begin
            want_next = e.layer - 2'd1;
            n_total++;
            if ({layer_valid, sample_valid, z_valid, z_prev_valid, layer} !== {4'b1111, want_next})
                $display("FAIL %s next_round: got valids %b layer %0d want 1111 layer %0d", tag,
                         {layer_valid, sample_valid, z_valid, z_prev_valid}, layer, want_next);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        zt[0] = {10'd300, 10'd400, 10'd600, 10'd700};
        zt[1] = {10'd1, 10'd2, 10'd3, 10'd4};
        zt[2] = {10'd5, 10'd6, 10'd7, 10'd8};
        zt[3] = {10'd9, 10'd10, 10'd11, 10'd12};
        start_pass(10'd5, LM + 1, 1'b0);
        test_round("basic_l3", 0, 0, 0, 0, 0);
        test_round("basic_l2", 0, 0, 0, 0, 0);
        test_round("basic_l1", 0, 0, 0, 0, 1);
    endtask

    task automatic test_staggered();
        for (int k = 0; k <= LM; k++) zt[k] = ZW'({$urandom(), $urandom()});
        start_pass(10'd6, LM + 1, 1'b0);
        test_round("stag_l3", 1, 4, 0, 0, 0);
        test_round("stag_l2", 1, 4, 0, 0, 0);
        test_round("stag_l1", 1, 4, 0, 0, 1);
    endtask

    task automatic test_update_ignored();
        for (int k = 0; k <= LM; k++) zt[k] = ZW'({$urandom(), $urandom()});
        start_pass(10'd7, LM + 1, 1'b1);
        test_round("ign_l3", 0, 2, 1, 0, 0);
        test_round("ign_l2", 2, 0, 1, 0, 0);
        test_round("ign_l1", 0, 3, 1, 0, 1);
    endtask

    task automatic test_busy_inputs();
        for (int k = 0; k <= LM; k++) zt[k] = ZW'({$urandom(), $urandom()});
        start_pass(10'd8, LM + 1, 1'b0);
        test_round("busy_l3", 0, 1, 0, 1, 0);
        test_round("busy_l2", 0, 0, 0, 1, 0);
        test_round("busy_l1", 1, 0, 0, 1, 1);
        start_pass(10'd9, LM + 1, 1'b0);
        test_round("after_l3", 0, 0, 0, 0, 0);
        test_round("after_l2", 0, 0, 0, 0, 0);
        test_round("after_l1", 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        start_pass(10'd11, 2, 1'b0);
        do_reset("rst_capture");
        start_pass(10'd12, LM + 1, 1'b0);
        test_round("pre_rst_l3", 0, 0, 0, 0, 0);
        do_reset("rst_issue");
        test_basic();
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        sample_in       = '0;
        fwd_z           = '0;
        clear_inputs();
        for (int k = 0; k <= LM; k++) zt[k] = '0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        test_reset("por");
        test_basic();
        test_staggered();
        test_update_ignored();
        test_busy_inputs();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
